// File: rtl/pixel_write_fifo_pkg.sv
// Shared constants and types for the pixel write FIFO.
//   PIX_W / MEM_DW : packed pixel width and RAM word width
//   *_LSB          : RGB packing positions inside the pixel word
//   state_e        : output-stage FSM states
package pixel_write_fifo_pkg;
  localparam int PIX_W  = 24;
  localparam int MEM_DW = 32;
  localparam int R_LSB  = 16;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 0;

  typedef enum logic {IDLE, REQ} state_e;

  function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_LSB +: 8] = r;
    p[G_LSB +: 8] = g;
    p[B_LSB +: 8] = b;
    return p;
  endfunction
endpackage

// File: rtl/pixel_write_fifo_if.sv
// Parser push port plus RAM request/ack write port.
//   master : the side driving pixels in and acking RAM requests
//   slave  : the FIFO block itself
interface pixel_write_fifo_if #(parameter int ADDR_W = 26);
  import pixel_write_fifo_pkg::*;
  logic              write_ram;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        red_r, green_r, blue_r;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_ack;

  modport master (output write_ram, addr, red_r, green_r, blue_r, mem_ack,
                  input  mem_req, mem_addr, mem_wdata);
  modport slave  (input  write_ram, addr, red_r, green_r, blue_r, mem_ack,
                  output mem_req, mem_addr, mem_wdata);
endinterface

// File: rtl/sync_fifo_ram.sv
// Generic register-array FIFO with write/read pointers and an entry count.
//   push/din   : store din at the write pointer
//   pop        : retire the head entry
//   dout       : head entry; dout_nxt : entry behind the head
//   count      : entries held (0..DEPTH)
// The caller must not push into a full FIFO unless it pops in the same cycle.
module sync_fifo_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [W-1:0]  dout_nxt,
  output logic [CW-1:0] count
);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];

  // Power-of-two depth: pointer arithmetic wraps naturally.
  always_comb begin
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop  ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  assign dout     = mem_q[rp_q];
  assign dout_nxt = mem_q[rp_q + AW'(1)];
  assign count    = cnt_q;
endmodule

// File: rtl/pixel_write_fifo.sv
// Buffers parser pixel writes and drains them to frame-buffer RAM.
//   clk/resetn  : clock, async active-low reset
//   bus         : parser push (write_ram/addr/rgb) and RAM port (mem_req/addr/wdata/ack)
//   clr_status  : clears overflow and drop_cnt (wins over a same-cycle drop)
//   fifo_full   : count == DEPTH;  fifo_level : entry count
//   overflow    : sticky dropped-push flag;  drop_cnt : saturating drop count
module pixel_write_fifo
  import pixel_write_fifo_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 26,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  pixel_write_fifo_if.slave   bus,
  input  logic                clr_status,
  output logic                fifo_full,
  output logic [LW-1:0]       fifo_level,
  output logic                overflow,
  output logic [15:0]         drop_cnt
);
  localparam int EW = ADDR_W + PIX_W;

  logic [LW-1:0]     count;
  logic [EW-1:0]     pix_in, head, head_nxt, load;
  logic              full, push, pop, drop, do_load;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [PIX_W-1:0]  mpix_q, mpix_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;

  assign pix_in = {bus.addr, pack_rgb(bus.red_r, bus.green_r, bus.blue_r)};
  assign full   = (count == LW'(DEPTH));
  assign pop    = (state_q == REQ) && bus.mem_ack;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign push   = bus.write_ram && (!full || pop);
  assign drop   = bus.write_ram && full && !pop;

  sync_fifo_ram #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push    (push),
    .pop     (pop),
    .din     (pix_in),
    .dout    (head),
    .dout_nxt(head_nxt),
    .count   (count)
  );

  // Output registers always mirror the current head. When the head is about to
  // be retired (or the FIFO is empty), the next head may be the incoming push,
  // which is taken straight from the inputs for one-cycle latency.
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    load    = head;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = REQ;
          do_load = 1'b1;
          load    = head;
        end else if (push) begin
          state_d = REQ;
          do_load = 1'b1;
          load    = pix_in;
        end
      end
      REQ: begin
        if (pop) begin
          if (count > LW'(1)) begin
            do_load = 1'b1;
            load    = head_nxt;
          end else if (push) begin
            do_load = 1'b1;
            load    = pix_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    maddr_d = do_load ? load[EW-1:PIX_W] : maddr_q;
    mpix_d  = do_load ? load[PIX_W-1:0]  : mpix_q;
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_status) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      maddr_q <= '0;
      mpix_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      mpix_q  <= mpix_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = {{(MEM_DW-PIX_W){1'b0}}, mpix_q};
  assign fifo_full     = full;
  assign fifo_level    = count;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;
endmodule
